// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, ACK levels, default address and a majority helper
// for the i2c_target block.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WR_ACK,
        READ,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h50;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronises scl/sda into clk, optionally majority-filters them
// and detects SCL edges plus START/STOP conditions.
//   clk, rst_n         system clock, async active-low reset
//   scl_i, sda_i       raw bus pins (idle high)
//   sda                synchronised (and filtered) SDA level
//   scl_rise, scl_fall one-clk SCL edge strobes
//   start_det          SDA fell while SCL high
//   stop_det           SDA rose while SCL high
// Macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter (+1 clk latency).
import i2c_pkg::*;

module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl_f, sda_f;
    logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
`endif

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        scl_hist_d = {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
        scl_f      = maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
        sda_f      = maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
`else
        scl_f      = scl_sync_q[SYNC_STAGES-1];
        sda_f      = sda_sync_q[SYNC_STAGES-1];
`endif
        scl_prev_d = scl_f;
        sda_prev_d = sda_f;
    end

    // Everything presets high so leaving reset on an idle bus yields no events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
            scl_hist_q <= '1;
            sda_hist_q <= '1;
`endif
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
`endif
        end
    end

    assign sda       = sda_f;
    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    // SCL must be high on both samples so a simultaneous SCL/SDA move is not a condition.
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: oversampled I2C target; matches a 7-bit address, ACKs, delivers
// write bytes and serialises read bytes. SCL is only sampled, never used as a clock.
//   clk, rst_n     system clock, async active-low reset
//   scl_i, sda_i   bus pins
//   sda_oe         1 = pull SDA low
//   ack_a          0 = target ACKs the current slot
//   busy           address matched, until STOP/START
//   rw             R/W bit of the last matched address
//   rx_data/valid  received write byte and its one-clk strobe
//   tx_data/tx_req read byte, captured in the clk where tx_req is high
// Macro I2C_TARGET_GLITCH_FILTER_EN enables the input glitch filter.
import i2c_pkg::*;

module i2c_target #(
    parameter int           N           = 7,
    parameter logic [N-1:0] TARGET_ADDR = N'(DEFAULT_TARGET_ADDR),
    parameter int           SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       ack_a,
    output logic       busy,
    output logic       rw,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req
);

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    // flag: byte complete (ADDR/WRITE) or sampled master ACK level (RD_ACK)
    logic       flag_q, flag_d;
    logic       sda_oe_q, sda_oe_d, ack_a_q, ack_a_d, busy_q, busy_d, rw_q, rw_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        flag_d     = flag_q;
        sda_oe_d   = sda_oe_q;
        ack_a_d    = ack_a_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req     = 1'b0;
        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            ack_a_d  = NACK;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd7;
            flag_d    = 1'b0;
            sda_oe_d  = 1'b0;
            ack_a_d   = NACK;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda};
                        if (bit_cnt_q == 3'd0) begin
                            if (shift_q == TARGET_ADDR) begin
                                rw_d   = sda;
                                busy_d = 1'b1;
                                flag_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (scl_fall && flag_q) begin
                        state_d  = ADDR_ACK;
                        sda_oe_d = 1'b1;
                        ack_a_d  = ACK;
                        flag_d   = 1'b0;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        ack_a_d   = NACK;
                        bit_cnt_d = 3'd7;
                        state_d   = WRITE;
                        if (rw_q) begin
                            tx_req   = 1'b1;
                            shift_d  = tx_data[6:0];
                            sda_oe_d = ~tx_data[7];
                            state_d  = READ;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda};
                        if (bit_cnt_q == 3'd0) begin
                            rx_data_d  = {shift_q, sda};
                            rx_valid_d = 1'b1;
                            flag_d     = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end else if (scl_fall && flag_q) begin
                        state_d  = WR_ACK;
                        sda_oe_d = 1'b1;
                        ack_a_d  = ACK;
                        flag_d   = 1'b0;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        ack_a_d   = NACK;
                        bit_cnt_d = 3'd7;
                        state_d   = WRITE;
                    end
                end
                READ: begin
                    // bit7 went out on entry; each fall shifts the next bit onto SDA.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            flag_d   = NACK;
                            state_d  = RD_ACK;
                        end else begin
                            sda_oe_d  = ~shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        flag_d = sda;
                    end else if (scl_fall) begin
                        if (flag_q == ACK) begin
                            tx_req    = 1'b1;
                            shift_d   = tx_data[6:0];
                            sda_oe_d  = ~tx_data[7];
                            bit_cnt_d = 3'd7;
                            state_d   = READ;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd7;
            shift_q    <= '0;
            flag_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
            ack_a_q    <= NACK;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            flag_q     <= flag_d;
            sda_oe_q   <= sda_oe_d;
            ack_a_q    <= ack_a_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign ack_a    = ack_a_q;
    assign busy     = busy_q;
    assign rw       = rw_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C master driving i2c_target with scoreboard queues
// for written and read bytes.
import i2c_pkg::*;

module tb_i2c_target;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1, glitch = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       scl_i, sda_i, sda_oe, ack_a, busy, rw, rx_valid, tx_req;
    logic [7:0] rx_data;

    int n_cmp = 0, n_err = 0, n_txreq = 0, n_both = 0, n_start = 0;
    logic [7:0] rx_obs[$], exp_rx[$], exp_tx[$];

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe & ~glitch;

    always #5 clk = ~clk;

    i2c_target u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_oe   (sda_oe),
        .ack_a    (ack_a),
        .busy     (busy),
        .rw       (rw),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req)
    );

    always @(negedge clk) begin
        if (rx_valid) rx_obs.push_back(rx_data);
        if (tx_req) n_txreq++;
        if (rx_valid && tx_req) n_both++;
        if (u_dut.start_det) n_start++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b, output logic bus_v, output logic oe_v, output logic ack_v);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        bus_v = sda_i; oe_v = sda_oe; ack_v = ack_a;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_v, output logic oe_v);
        logic bv, ov, av;
        for (int i = 7; i >= 0; i--) send_bit(b[i], bv, ov, av);
        send_bit(1'b1, bv, oe_v, ack_v);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic bv, ov, av;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, bv, ov, av);
            d[i] = bv;
        end
    endtask

    task automatic test_reset();
        wait_clk(3);
        n_cmp++;
        if ({sda_oe, ack_a, busy, rw, rx_data, rx_valid, tx_req} !== {4'b0100, 8'h00, 2'b00}) begin
            n_err++;
            $display("FAIL reset_in: got %b want %b", {sda_oe, ack_a, busy, rw, rx_data, rx_valid, tx_req}, {4'b0100, 8'h00, 2'b00});
        end
        rst_n = 1'b1;
        wait_clk(Q);
        n_cmp++;
        if ({sda_oe, ack_a, busy, rw, rx_data, rx_valid, tx_req} !== {4'b0100, 8'h00, 2'b00}) begin
            n_err++;
            $display("FAIL reset_out: got %b want %b", {sda_oe, ack_a, busy, rw, rx_data, rx_valid, tx_req}, {4'b0100, 8'h00, 2'b00});
        end
    endtask

    task automatic test_write();
        logic ak, oe;
        logic [7:0] e, o;
        bus_start();
        write_byte(8'hA0, ak, oe);
        n_cmp++;
        if ({ak, oe} !== 2'b01) begin n_err++; $display("FAIL wr_addr_ack: ack_a,sda_oe got %b want 01", {ak, oe}); end
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", busy); end
        exp_rx.push_back(8'hA5);
        write_byte(8'hA5, ak, oe);
        n_cmp++;
        if ({ak, oe} !== 2'b01) begin n_err++; $display("FAIL wr_data_ack: ack_a,sda_oe got %b want 01", {ak, oe}); end
        bus_stop();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL wr_stop_busy: got %b want 0", busy); end
        n_cmp++;
        if (rx_obs.size() != exp_rx.size()) begin n_err++; $display("FAIL wr_rx_count: got %0d want %0d", rx_obs.size(), exp_rx.size()); end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = (rx_obs.size() > 0) ? rx_obs.pop_front() : 8'hxx;
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL wr_rx_data: got %h want %h", o, e); end
        end
        rx_obs.delete();
    endtask

    task automatic test_addr_mismatch();
        logic ak, oe;
        logic [7:0] e, o;
        bus_start();
        write_byte(8'hA2, ak, oe);
        n_cmp++;
        if ({ak, oe} !== 2'b10) begin n_err++; $display("FAIL mm_no_ack: ack_a,sda_oe got %b want 10", {ak, oe}); end
        n_cmp++;
        if (u_dut.state_q !== IGNORE) begin n_err++; $display("FAIL mm_state: got %0d want %0d", u_dut.state_q, IGNORE); end
        write_byte(8'h77, ak, oe);
        bus_stop();
        n_cmp++;
        if (rx_obs.size() != 0) begin n_err++; $display("FAIL mm_rx_count: got %0d want 0", rx_obs.size()); end
        rx_obs.delete();
        bus_start();
        write_byte(8'hA0, ak, oe);
        n_cmp++;
        if ({ak, oe} !== 2'b01) begin n_err++; $display("FAIL mm_next_ack: ack_a,sda_oe got %b want 01", {ak, oe}); end
        exp_rx.push_back(8'h5A);
        write_byte(8'h5A, ak, oe);
        bus_stop();
        n_cmp++;
        if (rx_obs.size() != exp_rx.size()) begin n_err++; $display("FAIL mm_rx_count2: got %0d want %0d", rx_obs.size(), exp_rx.size()); end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = (rx_obs.size() > 0) ? rx_obs.pop_front() : 8'hxx;
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL mm_rx_data: got %h want %h", o, e); end
        end
        rx_obs.delete();
    endtask

    task automatic test_read();
        logic ak, oe, bv;
        logic [7:0] d, e;
        int t0;
        t0 = n_txreq;
        tx_data = 8'h3C;
        exp_tx.push_back(8'h3C);
        exp_tx.push_back(8'hC3);
        bus_start();
        write_byte(8'hA1, ak, oe);
        n_cmp++;
        if ({ak, oe} !== 2'b01) begin n_err++; $display("FAIL rd_addr_ack: ack_a,sda_oe got %b want 01", {ak, oe}); end
        read_byte(d);
        tx_data = 8'hC3;
        e = exp_tx.pop_front();
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL rd_byte0: got %h want %h", d, e); end
        send_bit(ACK, bv, oe, ak);
        read_byte(d);
        e = exp_tx.pop_front();
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL rd_byte1: got %h want %h", d, e); end
        send_bit(NACK, bv, oe, ak);
        n_cmp++;
        if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rd_release: sda_oe got %b want 0", sda_oe); end
        bus_stop();
        n_cmp++;
        if (n_txreq - t0 != 2) begin n_err++; $display("FAIL rd_txreq_count: got %0d want 2", n_txreq - t0); end
    endtask

    task automatic test_back_to_back();
        logic ak, oe, bv;
        logic [7:0] d, e, o;
        int t0;
        t0 = n_txreq;
        tx_data = 8'h96;
        exp_tx.push_back(8'h96);
        bus_start();
        write_byte(8'hA0, ak, oe);
        n_cmp++;
        if (rw !== 1'b0) begin n_err++; $display("FAIL b2b_rw0: got %b want 0", rw); end
        exp_rx.push_back(8'h11);
        write_byte(8'h11, ak, oe);
        bus_start();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_rs_busy: got %b want 0", busy); end
        write_byte(8'hA1, ak, oe);
        n_cmp++;
        if ({ak, oe, rw} !== 3'b011) begin n_err++; $display("FAIL b2b_rd_addr: ack_a,sda_oe,rw got %b want 011", {ak, oe, rw}); end
        n_cmp++;
        if (n_txreq - t0 != 1) begin n_err++; $display("FAIL b2b_txreq: got %0d want 1", n_txreq - t0); end
        read_byte(d);
        e = exp_tx.pop_front();
        n_cmp++;
        if (d !== e) begin n_err++; $display("FAIL b2b_rd_byte: got %h want %h", d, e); end
        send_bit(NACK, bv, oe, ak);
        bus_stop();
        n_cmp++;
        if (rx_obs.size() != exp_rx.size()) begin n_err++; $display("FAIL b2b_rx_count: got %0d want %0d", rx_obs.size(), exp_rx.size()); end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            o = (rx_obs.size() > 0) ? rx_obs.pop_front() : 8'hxx;
            n_cmp++;
            if (o !== e) begin n_err++; $display("FAIL b2b_rx_data: got %h want %h", o, e); end
        end
        rx_obs.delete();
    endtask

    task automatic test_reset_mid();
        logic ak, oe, bv, ov, av;
        logic [7:0] a;
        a = 8'hA0;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(a[i], bv, ov, av);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        n_cmp++;
        if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rm_pre_oe: got %b want 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sda_oe, ack_a} !== 2'b01) begin n_err++; $display("FAIL rm_async: sda_oe,ack_a got %b want 01", {sda_oe, ack_a}); end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
        write_byte(8'hA0, ak, oe);
        n_cmp++;
        if ({ak, oe, busy} !== 3'b100) begin n_err++; $display("FAIL rm_ignored: ack_a,sda_oe,busy got %b want 100", {ak, oe, busy}); end
        n_cmp++;
        if (rx_obs.size() != 0) begin n_err++; $display("FAIL rm_rx_count: got %0d want 0", rx_obs.size()); end
        rx_obs.delete();
        bus_stop();
        bus_start();
        write_byte(8'hA0, ak, oe);
        n_cmp++;
        if ({ak, oe} !== 2'b01) begin n_err++; $display("FAIL rm_recover_ack: ack_a,sda_oe got %b want 01", {ak, oe}); end
        bus_stop();
    endtask

    task automatic test_glitch();
        int s0, want;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        want = 0;
`else
        want = 1;
`endif
        scl_m = 1'b1; sda_m = 1'b1;
        wait_clk(Q);
        s0 = n_start;
        glitch = 1'b1;
        wait_clk(1);
        glitch = 1'b0;
        wait_clk(Q);
        n_cmp++;
        if (n_start - s0 != want) begin n_err++; $display("FAIL glitch_start: got %0d want %0d", n_start - s0, want); end
        n_cmp++;
        if (sda_oe !== 1'b0) begin n_err++; $display("FAIL glitch_oe: got %b want 0", sda_oe); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_glitch();
        n_cmp++;
        if (n_both != 0) begin n_err++; $display("FAIL rx_tx_overlap: got %0d want 0", n_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
